// File: rtl/cmd_stream_dispatcher.sv
// Routes a 32-bit AXI-Stream command stream to NUM_CHANNELS render-core inputs.
// A header word per packet selects unicast, broadcast or round-robin routing.

module cmd_dispatch_lane (
    input  logic aclk,
    input  logic resetn,
    input  logic fwd,
    input  logic in_valid,
    input  logic in_hs,
    input  logic dest,
    input  logic ready,
    output logic valid,
    output logic done
);
    logic accepted;

    // accepted masks a beat this channel already took while others stall
    assign valid = fwd & in_valid & dest & ~accepted;
    assign done  = ~dest | accepted | ready;

    always_ff @(posedge aclk) begin
        if (!resetn)             accepted <= 1'b0;
        else if (in_hs)          accepted <= 1'b0;
        else if (valid && ready) accepted <= 1'b1;
    end
endmodule

module cmd_stream_dispatcher #(
    parameter int NUM_CHANNELS     = 2,
    parameter int CMD_STREAM_WIDTH = 32,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                 aclk,
    input  logic                                 resetn,
    input  logic                                 s_cmd_axis_tvalid,
    output logic                                 s_cmd_axis_tready,
    input  logic                                 s_cmd_axis_tlast,
    input  logic [CMD_STREAM_WIDTH-1:0]          s_cmd_axis_tdata,
    output logic [NUM_CHANNELS-1:0]              m_cmd_axis_tvalid,
    input  logic [NUM_CHANNELS-1:0]              m_cmd_axis_tready,
    output logic [NUM_CHANNELS-1:0]              m_cmd_axis_tlast,
    output logic [NUM_CHANNELS*CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
    output logic [2:0]                           rr_pointer,
    output logic [CNT_WIDTH-1:0]                 dropped_packets,
    output logic                                 busy
);
    typedef logic [NUM_CHANNELS-1:0] chan_t;
    typedef enum logic [1:0] {HEADER, FORWARD, DROP} state_t;

    localparam logic [3:0] NCH     = 4'(NUM_CHANNELS);
    localparam logic [2:0] RR_LAST = 3'(NUM_CHANNELS - 1);

    state_t     state, state_nx;
    chan_t      dest_mask, hdr_mask, lane_done;
    logic [1:0] mode;
    logic [2:0] idx;
    logic       hdr_bad, fwd, in_hs;

    assign mode    = s_cmd_axis_tdata[31:30];
    assign idx     = s_cmd_axis_tdata[2:0];
    assign hdr_bad = (mode == 2'b11) || (mode == 2'b00 && {1'b0, idx} >= NCH);
    assign fwd     = (state == FORWARD);
    assign busy    = (state != HEADER);

    assign s_cmd_axis_tready = fwd ? &lane_done : 1'b1;
    assign in_hs             = s_cmd_axis_tvalid & s_cmd_axis_tready;
    assign m_cmd_axis_tlast  = {NUM_CHANNELS{s_cmd_axis_tlast}};
    assign m_cmd_axis_tdata  = {NUM_CHANNELS{s_cmd_axis_tdata}};

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
        cmd_dispatch_lane u_lane (
            .aclk     (aclk),
            .resetn   (resetn),
            .fwd      (fwd),
            .in_valid (s_cmd_axis_tvalid),
            .in_hs    (in_hs),
            .dest     (dest_mask[i]),
            .ready    (m_cmd_axis_tready[i]),
            .valid    (m_cmd_axis_tvalid[i]),
            .done     (lane_done[i])
        );
    end

    always_comb begin
        hdr_mask = '0;
        case (mode)
            2'b00:   hdr_mask = chan_t'(1) << idx;
            2'b01:   hdr_mask = '1;
            2'b10:   hdr_mask = chan_t'(1) << rr_pointer;
            default: hdr_mask = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            HEADER: begin
                if (in_hs && !s_cmd_axis_tlast)
                    state_nx = hdr_bad ? DROP : FORWARD;
            end
            FORWARD, DROP: begin
                if (in_hs && s_cmd_axis_tlast) state_nx = HEADER;
            end
            default: state_nx = HEADER;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state           <= HEADER;
            dest_mask       <= '0;
            rr_pointer      <= '0;
            dropped_packets <= '0;
        end else begin
            state <= state_nx;
            if (state == HEADER && in_hs) begin
                dest_mask <= hdr_mask;
                // empty round-robin packets still consume their turn
                if (mode == 2'b10)
                    rr_pointer <= (rr_pointer == RR_LAST) ? 3'd0 : rr_pointer + 3'd1;
                if (hdr_bad && dropped_packets != '1)
                    dropped_packets <= dropped_packets + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cmd_stream_dispatcher.sv
// Scoreboard bench for cmd_stream_dispatcher with two channels: expected beats
// are queued per channel when driven and checked as each channel handshakes.

module tb_cmd_stream_dispatcher;
    localparam int NCH = 2;
    localparam int W   = 32;

    logic               aclk = 1'b0;
    logic               resetn;
    logic               s_tvalid, s_tready, s_tlast;
    logic [W-1:0]       s_tdata;
    logic [NCH-1:0]     m_tvalid, m_tready, m_tlast;
    logic [NCH*W-1:0]   m_tdata;
    logic [2:0]         rr_pointer;
    logic [15:0]        dropped;
    logic               busy;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W:0] exp_q [NCH][$];

    always #5 aclk = ~aclk;

    cmd_stream_dispatcher #(.NUM_CHANNELS(NCH), .CMD_STREAM_WIDTH(W), .CNT_WIDTH(16)) dut (
        .aclk              (aclk),
        .resetn            (resetn),
        .s_cmd_axis_tvalid (s_tvalid),
        .s_cmd_axis_tready (s_tready),
        .s_cmd_axis_tlast  (s_tlast),
        .s_cmd_axis_tdata  (s_tdata),
        .m_cmd_axis_tvalid (m_tvalid),
        .m_cmd_axis_tready (m_tready),
        .m_cmd_axis_tlast  (m_tlast),
        .m_cmd_axis_tdata  (m_tdata),
        .rr_pointer        (rr_pointer),
        .dropped_packets   (dropped),
        .busy              (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Channel monitor: every output beat must match the head of its queue.
    always @(negedge aclk) begin
        for (int i = 0; i < NCH; i++) begin
            if (m_tvalid[i] && exp_q[i].size() == 0)
                chk($sformatf("ch%0d_unexpected_valid", i), 1, 0);
            else if (m_tvalid[i] && m_tready[i])
                chk($sformatf("ch%0d_beat", i), {m_tlast[i], m_tdata[i*W +: W]},
                    exp_q[i].pop_front());
        end
    end

    task automatic drive(input logic [W-1:0] d, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
    endtask

    task automatic wait_hs();
        logic hs;
        hs = 1'b0;
        for (int k = 0; k < 50 && !hs; k++) begin
            @(negedge aclk);
            hs = s_tready;
            @(posedge aclk);
            #1;
        end
        if (!hs) chk("hs_timeout", 0, 1);
        s_tvalid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l, input logic [NCH-1:0] to);
        for (int i = 0; i < NCH; i++)
            if (to[i]) exp_q[i].push_back({l, d});
        drive(d, l);
        wait_hs();
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_q0_empty"}, exp_q[0].size(), 0);
        chk({tag, "_q1_empty"}, exp_q[1].size(), 0);
    endtask

    initial begin
        resetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = '1;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tready", s_tready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rr", rr_pointer, 0);
        chk("rst_dropped", dropped, 0);
        resetn = 1'b1;
        @(posedge aclk); #1;

        // unicast to channel 1, zero-latency pass-through
        send(32'h0000_0001, 1'b0, 2'b00);
        chk("uc_busy", busy, 1);
        exp_q[1].push_back({1'b0, 32'hA000_0000});
        drive(32'hA000_0000, 1'b0);
        #1 chk("uc_same_cycle", m_tvalid, 2'b10);
        wait_hs();
        send(32'hA000_0001, 1'b0, 2'b10);
        send(32'hA000_0002, 1'b1, 2'b10);
        chk("uc_idle", busy, 0);
        chk_empty("uc");

        // broadcast with channel 1 stalled
        send(32'h4000_0000, 1'b0, 2'b00);
        m_tready = 2'b01;
        exp_q[0].push_back({1'b0, 32'hB000_0000});
        exp_q[1].push_back({1'b0, 32'hB000_0000});
        drive(32'hB000_0000, 1'b0);
        #1;
        chk("bc_valid_both", m_tvalid, 2'b11);
        chk("bc_stall0", s_tready, 0);
        @(posedge aclk); #1;
        chk("bc_ch0_dropped_valid", m_tvalid, 2'b10);
        chk("bc_stall1", s_tready, 0);
        repeat (2) begin
            @(posedge aclk); #1;
            chk("bc_stall_hold", s_tready, 0);
        end
        m_tready = 2'b11;
        #1 chk("bc_release", s_tready, 1);
        wait_hs();
        send(32'hB000_0001, 1'b1, 2'b11);
        chk_empty("bc");

        // three round-robin packets
        send(32'h8000_0000, 1'b0, 2'b00);
        chk("rr_ptr0", rr_pointer, 1);
        send(32'hC000_0000, 1'b1, 2'b01);
        send(32'h8000_0000, 1'b0, 2'b00);
        chk("rr_ptr1", rr_pointer, 0);
        send(32'hC000_0001, 1'b1, 2'b10);
        send(32'h8000_0000, 1'b0, 2'b00);
        chk("rr_ptr2", rr_pointer, 1);
        send(32'hC000_0002, 1'b1, 2'b01);
        chk_empty("rr");

        // bad unicast index drops payload
        send(32'h0000_0005, 1'b0, 2'b00);
        chk("drop_cnt", dropped, 1);
        chk("drop_busy", busy, 1);
        drive(32'hD000_0000, 1'b0);
        #1;
        chk("drop_no_valid", m_tvalid, 0);
        chk("drop_tready", s_tready, 1);
        wait_hs();
        send(32'hD000_0001, 1'b1, 2'b00);
        chk("drop_done", busy, 0);
        send(32'h0000_0000, 1'b0, 2'b00);
        send(32'hE000_0000, 1'b1, 2'b01);
        chk_empty("drop");

        // empty packets: reserved mode, unicast, round-robin
        send(32'hC000_0000, 1'b1, 2'b00);
        chk("rsv_cnt", dropped, 2);
        chk("rsv_busy", busy, 0);
        send(32'h0000_0001, 1'b1, 2'b00);
        chk("empty_uc_busy", busy, 0);
        chk("empty_uc_rr", rr_pointer, 1);
        send(32'h8000_0000, 1'b1, 2'b00);
        chk("empty_rr_adv", rr_pointer, 0);
        chk("empty_rr_busy", busy, 0);

        // reset mid-broadcast with channel 1 stalled
        send(32'h4000_0000, 1'b0, 2'b00);
        m_tready = 2'b01;
        exp_q[0].push_back({1'b1, 32'hF000_0000});
        exp_q[1].push_back({1'b1, 32'hF000_0000});
        drive(32'hF000_0000, 1'b1);
        @(posedge aclk); #1;
        chk("mid_ch1_pending", m_tvalid, 2'b10);
        resetn = 1'b0;
        s_tvalid = 1'b0;
        @(posedge aclk); #1;
        resetn = 1'b1;
        exp_q[1].delete();
        chk("mrst_tvalid", m_tvalid, 0);
        chk("mrst_tready", s_tready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_dropped", dropped, 0);
        chk("mrst_rr", rr_pointer, 0);

        // accepted cleared: a fresh broadcast reaches both channels
        m_tready = 2'b11;
        send(32'h4000_0000, 1'b0, 2'b00);
        drive(32'h1234_5678, 1'b1);
        exp_q[0].push_back({1'b1, 32'h1234_5678});
        exp_q[1].push_back({1'b1, 32'h1234_5678});
        #1 chk("post_rst_valid", m_tvalid, 2'b11);
        wait_hs();
        @(posedge aclk); #1;
        chk_empty("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
